// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared pipeline definitions used by the fetch, decode and execute stages.
//   PC_RESET_DEFAULT : default first fetch address after reset
//   NOP_INST_DEFAULT : addi x0,x0,0, the filler word for an empty IF/ID register
//   fetch_state_t    : fetch FSM state encoding (RUN / HALTED)
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
// Free-running 32-bit event counter. Wraps from all-ones to zero.
//   clock : rising-edge clock
//   reset : synchronous active-high clear (dominates inc)
//   inc   : add one on this edge
//   count : current count value
// -----------------------------------------------------------------------------
module perf_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 32'd0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, reads instruction memory
// combinationally and fills the IF/ID pipeline register.
//
// Ports
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   imem_addr        : instruction memory address (= PC register)
//   imem_data        : instruction word for imem_addr, same cycle
//   redirect_valid   : taken branch/jump from execute
//   redirect_pc      : redirect target (low two bits ignored)
//   halt_req         : stop fetching
//   id_ready         : decode consumes IF/ID this cycle
//   if_valid/if_pc/if_inst : IF/ID register contents
//   halted           : FSM is in HALTED (doubles as the state debug view)
//   fetch_count      : instructions loaded into IF/ID
//   flush_count      : live instructions squashed by redirect
//
// Handshake: IF/ID transfers to decode on any edge where if_valid && id_ready.
// if_valid never drops without that transfer except on redirect/reset, and
// if_pc/if_inst stay stable while if_valid && !id_ready.
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         load;
    logic         flush_inc;

    assign imem_addr = pc;

    // A new word enters IF/ID only when running, not being redirected or
    // halted, and the slot is empty or being drained this cycle.
    assign load = (state == RUN) && !redirect_valid && !halt_req
                  && (!if_valid || id_ready);

    assign flush_inc = redirect_valid && if_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            halted   <= 1'b0;
            pc       <= PC_RESET;
            if_valid <= 1'b0;
            if_pc    <= 32'd0;
            if_inst  <= NOP_INST;
        end else if (redirect_valid) begin
            // Redirect wins over halt, stall and load; it also restarts a
            // halted stage.
            state    <= RUN;
            halted   <= 1'b0;
            pc       <= align_word(redirect_pc);
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else begin
            if (state == RUN && halt_req) begin
                state  <= HALTED;
                halted <= 1'b1;
            end
            if (load) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= imem_data;
                pc       <= pc + 32'd4;
            end else if (if_valid && id_ready) begin
                // Consumed with nothing to replace it (halting or halted).
                if_valid <= 1'b0;
                if_inst  <= NOP_INST;
            end
        end
    end

    perf_counter u_fetch_counter (
        .clock (clock),
        .reset (reset),
        .inc   (load),
        .count (fetch_count)
    );

    perf_counter u_flush_counter (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] PC_RST = 32'h0100_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'd0;
    logic        halt_req       = 1'b0;
    logic        id_ready       = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .halted         (halted),
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
    );

    // Instruction memory: a fixed scramble of the address so every word
    // differs and a wrong capture address shows up in if_inst.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_0F01;
    endfunction

    assign imem_data = mem_word(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_inst;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    // Expected-value queue for the observed outputs of one cycle.
    logic [31:0] exp_q[$];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, observed,
                     expected, $time);
        end
    endtask

    // One fetch step described as what happens to the "slot" and the PC.
    task automatic model_step(input logic rst, input logic rv,
                              input logic [31:0] rpc, input logic hr,
                              input logic rdy);
        logic can_fetch;
        if (rst) begin
            m_pc = PC_RST; m_halted = 0; m_valid = 0; m_if_pc = 0;
            m_if_inst = NOP; m_fetch = 0; m_flush = 0;
        end else if (rv) begin
            if (m_valid) m_flush = m_flush + 1;
            m_pc      = rpc & 32'hFFFF_FFFC;
            m_valid   = 0;
            m_if_inst = NOP;
            m_halted  = 0;
        end else begin
            can_fetch = !m_halted && !hr;
            if (!m_valid || rdy) begin
                if (can_fetch) begin
                    m_valid   = 1;
                    m_if_pc   = m_pc;
                    m_if_inst = mem_word(m_pc);
                    m_pc      = m_pc + 4;
                    m_fetch   = m_fetch + 1;
                end else begin
                    m_valid   = 0;
                    m_if_inst = NOP;
                end
            end
            if (hr) m_halted = 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                         input logic hr, input logic rdy);
        @(negedge clock);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        id_ready       = rdy;
        model_step(rst, rv, rpc, hr, rdy);
        exp_q.push_back(m_pc);
        exp_q.push_back({31'd0, m_valid});
        exp_q.push_back(m_if_pc);
        exp_q.push_back(m_if_inst);
        exp_q.push_back({31'd0, m_halted});
        exp_q.push_back(m_fetch);
        exp_q.push_back(m_flush);
        @(posedge clock);
        #1;
        // ---------------- scoreboard ----------------
        check_val("imem_addr",   imem_addr,          exp_q.pop_front());
        check_val("if_valid",    {31'd0, if_valid},  exp_q.pop_front());
        check_val("if_pc",       if_pc,              exp_q.pop_front());
        check_val("if_inst",     if_inst,            exp_q.pop_front());
        check_val("halted",      {31'd0, halted},    exp_q.pop_front());
        check_val("fetch_count", fetch_count,        exp_q.pop_front());
        check_val("flush_count", flush_count,        exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset, then three consumed fetches.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        check_val("rst_if_inst", if_inst, NOP);
        check_val("rst_addr", imem_addr, PC_RST);
        cycle(0, 0, 0, 0, 1);
        check_val("first_pc", if_pc, 32'h0100_0000);
        check_val("first_inst", if_inst, mem_word(32'h0100_0000));
        cycle(0, 0, 0, 0, 1);
        check_val("second_pc", if_pc, 32'h0100_0004);
        cycle(0, 0, 0, 0, 1);
        check_val("third_pc", if_pc, 32'h0100_0008);
        check_val("three_fetches", fetch_count, 32'd3);

        // Stall with if_pc = 0x01000004.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_val("stall_pc", if_pc, 32'h0100_0004);
        check_val("stall_inst", if_inst, mem_word(32'h0100_0004));
        check_val("stall_addr", imem_addr, 32'h0100_0008);
        check_val("stall_fetches", fetch_count, 32'd2);

        // Redirect to an unaligned target while the slot is live.
        cycle(0, 1, 32'h0100_0102, 0, 0);
        check_val("redir_valid", {31'd0, if_valid}, 32'd0);
        check_val("redir_inst", if_inst, NOP);
        check_val("redir_addr", imem_addr, 32'h0100_0100);
        check_val("redir_flush", flush_count, 32'd1);
        cycle(0, 0, 0, 0, 1);
        check_val("redir_if_pc", if_pc, 32'h0100_0100);

        // One-cycle halt, an idle cycle, then restart via redirect.
        cycle(0, 0, 0, 1, 1);
        check_val("halt_flag", {31'd0, halted}, 32'd1);
        check_val("halt_drain", {31'd0, if_valid}, 32'd0);
        cycle(0, 0, 0, 0, 1);
        check_val("halt_frozen", imem_addr, 32'h0100_0104);
        cycle(0, 1, 32'h0100_0040, 0, 1);
        check_val("restart_flag", {31'd0, halted}, 32'd0);
        cycle(0, 0, 0, 0, 1);
        check_val("restart_pc", if_pc, 32'h0100_0040);

        // Redirect and halt together: redirect only.
        cycle(0, 1, 32'h0100_0200, 1, 1);
        check_val("both_halted", {31'd0, halted}, 32'd0);
        check_val("both_pc", imem_addr, 32'h0100_0200);

        // Reset during a stall, also with a redirect present.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 32'h0000_0800, 0, 0);
        check_val("rst_stall_valid", {31'd0, if_valid}, 32'd0);
        check_val("rst_stall_addr", imem_addr, PC_RST);
        check_val("rst_stall_fetch", fetch_count, 32'd0);
        check_val("rst_stall_flush", flush_count, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic        r_rv;
            logic        r_hr;
            logic        r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_hr  = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_pc  = $urandom;
            cycle(r_rst, r_rv, r_pc, r_hr, r_rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
